// File: rtl/mod_counter_adj_if.sv
// Control/status bundle for one digit stage of a clock chain: count/adjust
// controls in, value and cascade pulses out.
interface mod_counter_adj_if #(
  parameter int WIDTH = 6
);
  logic             i_en;
  logic             i_dir;
  logic [WIDTH-1:0] i_limit;
  logic             i_clr;
  logic             i_load;
  logic [WIDTH-1:0] i_load_val;
  logic             i_adj;
  logic             i_tick;
  logic             o_en;
  logic             o_borrow;
  logic [WIDTH-1:0] o_counter;
  logic             o_adj_active;

  modport master (
    output i_en, i_dir, i_limit, i_clr, i_load, i_load_val, i_adj, i_tick,
    input  o_en, o_borrow, o_counter, o_adj_active
  );

  modport slave (
    input  i_en, i_dir, i_limit, i_clr, i_load, i_load_val, i_adj, i_tick,
    output o_en, o_borrow, o_counter, o_adj_active
  );
endinterface

// File: rtl/mod_counter_adj.sv
// Up/down modulo counter with runtime limit, carry/borrow cascade pulses and a
// press/hold/auto-repeat adjust FSM for setting clock digits.
module mod_counter_adj #(
  parameter int WIDTH        = 6,
  parameter int HOLD_TICKS   = 4,
  parameter int REPEAT_TICKS = 1,
  parameter int ADJ_CARRY    = 0
) (
  input logic              i_clk,
  input logic              i_rst,
  mod_counter_adj_if.slave bus
);
  localparam int MAXT = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int TW   = $clog2(MAXT + 1);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_TICKS - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_TICKS - 1);
  localparam logic [TW-1:0] TICK_MAX    = {TW{1'b1}};
  localparam bit ADJ_PULSE = (ADJ_CARRY != 0);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  state_t           state;
  logic [TW-1:0]    tick_cnt;
  logic [TW-1:0]    tick_inc;
  logic             armed;
  logic             adj_active_q;
  logic [WIDTH-1:0] cnt_q;
  logic             en_q;
  logic             borrow_q;

  logic [WIDTH:0]   modulus;
  logic [WIDTH:0]   modulus_m1;
  logic [WIDTH-1:0] top;
  logic             load_ok;
  logic             adj_step;
  logic             en_step;
  logic             wrap_up;
  logic             wrap_dn;
  logic [WIDTH-1:0] step_val;

  // A zero limit selects the full 2^WIDTH range, so the modulus needs one extra bit.
  assign modulus    = (bus.i_limit == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, bus.i_limit};
  assign modulus_m1 = modulus - {{WIDTH{1'b0}}, 1'b1};
  assign top        = modulus_m1[WIDTH-1:0];
  assign load_ok    = ({1'b0, bus.i_load_val} < modulus);
  assign tick_inc   = (tick_cnt == TICK_MAX) ? tick_cnt : tick_cnt + TW'(1);

  always_comb begin
    adj_step = 1'b0;
    unique case (state)
      S_IDLE:   adj_step = bus.i_adj & armed;
      S_HOLD:   adj_step = bus.i_adj & bus.i_tick & (tick_cnt == HOLD_LAST);
      S_REPEAT: adj_step = bus.i_adj & bus.i_tick & (tick_cnt == REPEAT_LAST);
      default:  adj_step = 1'b0;
    endcase
  end

  // The count freezes while the user is setting the digit.
  assign en_step = bus.i_en & ~adj_active_q;

  always_comb begin
    wrap_up  = (cnt_q >= top);
    wrap_dn  = (cnt_q == '0);
    step_val = '0;
    if (!bus.i_dir) begin
      step_val = wrap_up ? '0 : cnt_q + WIDTH'(1);
    end else if (wrap_dn || cnt_q > top) begin
      step_val = top;
    end else begin
      step_val = cnt_q - WIDTH'(1);
    end
  end

  // Adjust FSM; a new press needs the button to have been seen low first.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      tick_cnt     <= '0;
      armed        <= 1'b0;
      adj_active_q <= 1'b0;
    end else begin
      armed <= ~bus.i_adj | (armed & (state != S_IDLE));
      unique case (state)
        S_IDLE: begin
          if (bus.i_adj && armed) begin
            state        <= S_HOLD;
            tick_cnt     <= '0;
            adj_active_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (!bus.i_adj) begin
            state        <= S_IDLE;
            adj_active_q <= 1'b0;
          end else if (bus.i_tick) begin
            if (tick_cnt == HOLD_LAST) begin
              state    <= S_REPEAT;
              tick_cnt <= '0;
            end else begin
              tick_cnt <= tick_inc;
            end
          end
        end
        S_REPEAT: begin
          if (!bus.i_adj) begin
            state        <= S_IDLE;
            adj_active_q <= 1'b0;
          end else if (bus.i_tick) begin
            tick_cnt <= (tick_cnt == REPEAT_LAST) ? '0 : tick_inc;
          end
        end
        default: begin
          state        <= S_IDLE;
          adj_active_q <= 1'b0;
        end
      endcase
    end
  end

  // Counter datapath: clear > load > adjust step > count enable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q    <= '0;
      en_q     <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      en_q     <= 1'b0;
      borrow_q <= 1'b0;
      if (bus.i_clr) begin
        cnt_q <= '0;
      end else if (bus.i_load) begin
        cnt_q <= load_ok ? bus.i_load_val : '0;
      end else if (adj_step) begin
        cnt_q    <= step_val;
        en_q     <= ADJ_PULSE & ~bus.i_dir & wrap_up;
        borrow_q <= ADJ_PULSE & bus.i_dir & wrap_dn;
      end else if (en_step) begin
        cnt_q    <= step_val;
        en_q     <= ~bus.i_dir & wrap_up;
        borrow_q <= bus.i_dir & wrap_dn;
      end
    end
  end

  assign bus.o_counter    = cnt_q;
  assign bus.o_en         = en_q;
  assign bus.o_borrow     = borrow_q;
  assign bus.o_adj_active = adj_active_q;
endmodule

// File: tb/tb_mod_counter_adj.sv
// Bench for mod_counter_adj: two instances (silent / pulsing adjust wraps) share
// stimulus and are checked every cycle against a tick-count reference model.
module tb_mod_counter_adj;
  localparam int W  = 6;
  localparam int HT = 4;
  localparam int RT = 2;

  logic clk;
  logic rst;
  int   n_tot  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  mod_counter_adj_if #(.WIDTH(W)) b0 ();
  mod_counter_adj_if #(.WIDTH(W)) b1 ();

  assign b1.i_en       = b0.i_en;
  assign b1.i_dir      = b0.i_dir;
  assign b1.i_limit    = b0.i_limit;
  assign b1.i_clr      = b0.i_clr;
  assign b1.i_load     = b0.i_load;
  assign b1.i_load_val = b0.i_load_val;
  assign b1.i_adj      = b0.i_adj;
  assign b1.i_tick     = b0.i_tick;

  mod_counter_adj #(.WIDTH(W), .HOLD_TICKS(HT), .REPEAT_TICKS(RT), .ADJ_CARRY(0))
    u_dut0 (.i_clk(clk), .i_rst(rst), .bus(b0.slave));
  mod_counter_adj #(.WIDTH(W), .HOLD_TICKS(HT), .REPEAT_TICKS(RT), .ADJ_CARRY(1))
    u_dut1 (.i_clk(clk), .i_rst(rst), .bus(b1.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: the adjust behaviour is expressed as "ticks seen since the
  // press"; steps fall on tick HT, HT+RT, HT+2RT, ...
  int m_cnt, m_ticks, m_mod;
  bit m_car, m_bor, m_by_adj, m_held, m_armed;
  bit m_was_held, m_adj_go, m_en_go, m_wrap;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_car = 0; m_bor = 0; m_by_adj = 0;
      m_held = 0; m_armed = 0; m_ticks = 0;
    end else begin
      m_mod      = (b0.i_limit == 0) ? (1 << W) : int'(b0.i_limit);
      m_was_held = m_held;
      m_adj_go   = 0;
      if (!m_held) begin
        if (b0.i_adj && m_armed) begin
          m_adj_go = 1; m_held = 1; m_ticks = 0;
        end
      end else if (!b0.i_adj) begin
        m_held = 0;
      end else if (b0.i_tick) begin
        m_ticks++;
        if (m_ticks == HT || (m_ticks > HT && (m_ticks - HT) % RT == 0)) m_adj_go = 1;
      end
      if (!b0.i_adj) m_armed = 1;
      else if (!m_was_held) m_armed = 0;

      m_en_go = b0.i_en && !m_was_held;
      m_car = 0; m_bor = 0; m_by_adj = 0; m_wrap = 0;
      if (b0.i_clr) m_cnt = 0;
      else if (b0.i_load) m_cnt = (int'(b0.i_load_val) < m_mod) ? int'(b0.i_load_val) : 0;
      else if (m_adj_go || m_en_go) begin
        if (!b0.i_dir) begin
          if (m_cnt >= m_mod - 1) begin m_cnt = 0; m_wrap = 1; end
          else m_cnt++;
        end else begin
          if (m_cnt == 0) begin m_cnt = m_mod - 1; m_wrap = 1; end
          else if (m_cnt > m_mod - 1) m_cnt = m_mod - 1;
          else m_cnt--;
        end
        m_car    = m_wrap && !b0.i_dir;
        m_bor    = m_wrap && b0.i_dir;
        m_by_adj = m_adj_go;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cnt0"}, 32'(b0.o_counter), m_cnt);
    chk({tag, ".cnt1"}, 32'(b1.o_counter), m_cnt);
    chk({tag, ".en0"},  32'(b0.o_en),      32'(m_car && !m_by_adj));
    chk({tag, ".en1"},  32'(b1.o_en),      32'(m_car));
    chk({tag, ".bor0"}, 32'(b0.o_borrow),  32'(m_bor && !m_by_adj));
    chk({tag, ".bor1"}, 32'(b1.o_borrow),  32'(m_bor));
    chk({tag, ".act0"}, 32'(b0.o_adj_active), 32'(m_held));
    chk({tag, ".act1"}, 32'(b1.o_adj_active), 32'(m_held));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  logic [W-1:0] lims [6] = '{6'd60, 6'd24, 6'd12, 6'd7, 6'd1, 6'd0};
  int en0_cnt, en1_cnt;

  initial begin
    rst = 1'b1;
    b0.i_en = 0; b0.i_dir = 0; b0.i_limit = 6'd60; b0.i_clr = 0;
    b0.i_load = 0; b0.i_load_val = 0; b0.i_adj = 0; b0.i_tick = 0;
    repeat (3) @(negedge clk);
    chk("reset.cnt", 32'(b0.o_counter), 0);
    chk("reset.en",  32'(b0.o_en), 0);
    chk("reset.bor", 32'(b0.o_borrow), 0);
    chk("reset.act", 32'(b0.o_adj_active), 0);
    check_all("reset");
    rst = 1'b0;

    // Up count through a 60-wrap.
    b0.i_en = 1;
    for (int i = 1; i <= 61; i++) begin
      cyc("t1");
      chk("t1.val",   32'(b0.o_counter), i % 60);
      chk("t1.carry", 32'(b0.o_en), 32'(i == 60));
    end

    // Down wrap with borrow, out-of-range load.
    b0.i_en = 0; b0.i_dir = 1; b0.i_limit = 6'd24; b0.i_clr = 1;
    cyc("t2.clr");
    b0.i_clr = 0; b0.i_en = 1;
    cyc("t2.dn");
    chk("t2.val23", 32'(b0.o_counter), 23);
    chk("t2.bor",   32'(b0.o_borrow), 1);
    b0.i_en = 0;
    cyc("t2.idle");
    chk("t2.bor_low", 32'(b0.o_borrow), 0);
    b0.i_load = 1; b0.i_load_val = 6'd30;
    cyc("t2.load");
    chk("t2.load_oor", 32'(b0.o_counter), 0);

    // Limit lowered under an existing value.
    b0.i_dir = 0; b0.i_limit = 6'd60; b0.i_load_val = 6'd50;
    cyc("t3.load");
    b0.i_load = 0; b0.i_limit = 6'd24; b0.i_en = 1;
    cyc("t3.up");
    chk("t3.up_wrap", 32'(b0.o_counter), 0);
    chk("t3.up_carry", 32'(b0.o_en), 1);
    b0.i_en = 0; b0.i_limit = 6'd60; b0.i_load = 1;
    cyc("t3.load2");
    b0.i_load = 0; b0.i_limit = 6'd24; b0.i_dir = 1; b0.i_en = 1;
    cyc("t3.dn");
    chk("t3.dn_clamp", 32'(b0.o_counter), 23);
    chk("t3.dn_noborrow", 32'(b0.o_borrow), 0);

    // Adjust: press, hold, auto-repeat across the 59->0 wrap.
    b0.i_en = 0; b0.i_dir = 0; b0.i_limit = 6'd60; b0.i_load = 1; b0.i_load_val = 6'd57;
    cyc("t4.load");
    b0.i_load = 0; b0.i_adj = 1;
    en0_cnt = 0; en1_cnt = 0;
    for (int i = 0; i < 90; i++) begin
      b0.i_tick = (i % 10 == 9);
      b0.i_en   = ($urandom % 2) == 1;
      cyc("t4");
      en0_cnt += int'(b0.o_en);
      en1_cnt += int'(b1.o_en);
      if (i == 0) chk("t4.press", 32'(b0.o_counter), 58);
    end
    chk("t4.final", 32'(b0.o_counter), 1);
    chk("t4.silent_wrap", en0_cnt, 0);
    chk("t5.adj_carry", en1_cnt, 1);
    b0.i_tick = 0; b0.i_en = 0; b0.i_adj = 0;
    cyc("t4.rel");
    chk("t4.release", 32'(b0.o_adj_active), 0);

    // Async reset mid-repeat, then a held button must not step.
    b0.i_adj = 1;
    for (int i = 0; i < 60; i++) begin
      b0.i_tick = (i % 10 == 9);
      cyc("t6.hold");
    end
    b0.i_tick = 0;
    #2 rst = 1'b1;
    #1;
    chk("t6.rst_cnt0", 32'(b0.o_counter), 0);
    chk("t6.rst_cnt1", 32'(b1.o_counter), 0);
    chk("t6.rst_act",  32'(b0.o_adj_active), 0);
    chk("t6.rst_en",   32'(b1.o_en), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      b0.i_tick = (i % 10 == 9);
      cyc("t6.stuck");
    end
    chk("t6.no_step", 32'(b0.o_counter), 0);
    chk("t6.no_act",  32'(b0.o_adj_active), 0);
    b0.i_tick = 0; b0.i_adj = 0;
    cyc("t6.up");
    b0.i_adj = 1;
    cyc("t6.press");
    chk("t6.repress", 32'(b0.o_counter), 1);
    chk("t6.active",  32'(b0.o_adj_active), 1);
    b0.i_adj = 0;
    cyc("t6.rel");

    // Randomised mix of every control.
    for (int i = 0; i < 1500; i++) begin
      b0.i_en       = ($urandom % 3) == 0;
      if ($urandom % 16 == 0) b0.i_dir = ~b0.i_dir;
      b0.i_clr      = ($urandom % 40) == 0;
      b0.i_load     = ($urandom % 30) == 0;
      b0.i_load_val = W'($urandom);
      b0.i_tick     = ($urandom % 3) == 0;
      if ($urandom % 12 == 0) b0.i_adj = ~b0.i_adj;
      if ($urandom % 80 == 0) b0.i_limit = lims[$urandom % 6];
      cyc("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
